// File: rtl/palette_fader.sv
// palette_fader: output stage that sits directly after the palette ROM.
// It scales the 6-bit RRGGBB colour by a 2-bit brightness level and blanks
// it outside the active area. The syncs are delayed by one cycle so they
// stay aligned with the colour, and everything is packed onto the TinyVGA
// output byte. The block also owns the ROM's palette id. A swap request
// fades the picture out one level per step, changes the palette while the
// screen is black, and then fades back in. Steps are counted in frames.
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   color_in[5:0]     RRGGBB from the palette ROM for the current pixel
//   de_in             display enable, same cycle as color_in
//   hsync_in/vsync_in syncs, same cycle as color_in; asserted level is SYNC_POL
//   pid_req[1:0]      palette id to switch to
//   swap_req          one-cycle strobe that starts a fade/swap; ignored while busy
//   pid[1:0]          palette id driven to the ROM
//   busy              high whenever the fader is not idle
//   uo_out[7:0]       {hsync, B0, G0, R0, vsync, B1, G1, R1}
module palette_fader #(
  parameter int FRAMES_PER_STEP = 4,
  parameter bit SYNC_POL        = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] color_in,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] pid_req,
  input  logic       swap_req,
  output logic [1:0] pid,
  output logic       busy,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;

  localparam logic [7:0] CNT_MAX = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] UO_RST  = {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};

  state_t     state_q;
  logic [1:0] lvl_q, pid_q, pid_lat_q;
  logic [7:0] cnt_q;
  logic       busy_q, vs_prev_q;
  logic [7:0] uo_q, uo_d;
  logic       vs_act, tick;
  logic [1:0] ch_in  [3];   // 0 = R, 1 = G, 2 = B
  logic [1:0] ch_out [3];

  // Returns floor((c*l+1)/3). At l=3 this is the identity, and at l=0 it is 0.
  function automatic logic [1:0] scale(input logic [1:0] c, input logic [1:0] l);
    logic [3:0] p, q;
    p = {2'b00, c} * {2'b00, l} + 4'd1;
    q = p / 4'd3;
    return q[1:0];
  endfunction

  assign ch_in[0] = color_in[5:4];
  assign ch_in[1] = color_in[3:2];
  assign ch_in[2] = color_in[1:0];

  for (genvar i = 0; i < 3; i++) begin : g_ch
    assign ch_out[i] = de_in ? scale(ch_in[i], lvl_q) : 2'b00;
  end

  assign uo_d = {hsync_in, ch_out[2][0], ch_out[1][0], ch_out[0][0],
                 vsync_in, ch_out[2][1], ch_out[1][1], ch_out[0][1]};

  // A frame tick is the edge where vsync goes from inactive to asserted.
  // vs_prev_q resets to "inactive", so the first vsync after reset also ticks.
  assign vs_act = (vsync_in == SYNC_POL);
  assign tick   = vs_act & ~vs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_q      <= UO_RST;
      vs_prev_q <= 1'b0;
    end else begin
      uo_q      <= uo_d;
      vs_prev_q <= vs_act;
    end
  end

  // Fade/swap control. The counter only advances on ticks in the fade states,
  // so a tick that coincides with accepting a request (in IDLE) is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lvl_q     <= 2'd3;
      cnt_q     <= 8'd0;
      pid_q     <= 2'd0;
      pid_lat_q <= 2'd0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (swap_req) begin
          pid_lat_q <= pid_req;
          cnt_q     <= 8'd0;
          busy_q    <= 1'b1;
          state_q   <= FADE_OUT;
        end
        FADE_OUT: if (tick) begin
          if (cnt_q == CNT_MAX) begin
            cnt_q <= 8'd0;
            lvl_q <= lvl_q - 2'd1;
            if (lvl_q == 2'd1) state_q <= SWAP;
          end else cnt_q <= cnt_q + 8'd1;
        end
        SWAP: begin
          // The palette changes only at lvl 0, so the switch is never visible.
          pid_q   <= pid_lat_q;
          cnt_q   <= 8'd0;
          state_q <= FADE_IN;
        end
        FADE_IN: if (tick) begin
          if (cnt_q == CNT_MAX) begin
            cnt_q <= 8'd0;
            lvl_q <= lvl_q + 2'd1;
            if (lvl_q == 2'd2) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else cnt_q <= cnt_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pid    = pid_q;
  assign busy   = busy_q;
  assign uo_out = uo_q;

endmodule

// File: tb/tb_palette_fader.sv
module tb_palette_fader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] color_in = '0;
  logic       de_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [1:0] pid_req = '0;
  logic       swap_req = 1'b0;
  logic [1:0] pid;
  logic       busy;
  logic [7:0] uo_out;

  int n_chk = 0, n_fail = 0;

  palette_fader #(.FRAMES_PER_STEP(1), .SYNC_POL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .color_in(color_in), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pid_req(pid_req),
    .swap_req(swap_req), .pid(pid), .busy(busy), .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] color;
    logic       de, hs, vs;
    logic [7:0] exp_uo;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Produces one frame tick: vsync goes low for a cycle and then back high.
  task automatic frame_tick();
    @(negedge clk) vsync_in = 1'b0;
    @(negedge clk) vsync_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_uo", uo_out, 8'h88);
    check("rst_pid", {6'b0, pid}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    #3 rst_n = 1'b1;
  endtask

  task automatic request(input logic [1:0] id);
    @(negedge clk) begin swap_req = 1'b1; pid_req = id; end
    @(negedge clk) swap_req = 1'b0;
  endtask

  initial begin
    int nt;
    vecs[0] = '{6'b111010, 1'b1, 1'b1, 1'b1, 8'h9F};
    vecs[1] = '{6'b111010, 1'b0, 1'b1, 1'b1, 8'h88};
    vecs[2] = '{6'b111010, 1'b1, 1'b0, 1'b1, 8'h1F};
    vecs[3] = '{6'b111010, 1'b0, 1'b1, 1'b0, 8'h80};
    vecs[4] = '{6'b000000, 1'b1, 1'b1, 1'b1, 8'h88};
    vecs[5] = '{6'b111111, 1'b1, 1'b1, 1'b1, 8'hFF};
    vecs[6] = '{6'b010101, 1'b1, 1'b1, 1'b1, 8'hF8};
    vecs[7] = '{6'b100100, 1'b1, 1'b1, 1'b1, 8'hA9};
    vecs[8] = '{6'b110001, 1'b1, 1'b0, 1'b0, 8'h51};

    do_reset();

    // Table-driven vectors at full brightness in IDLE.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk) begin
        color_in = vecs[i].color; de_in = vecs[i].de;
        hsync_in = vecs[i].hs;    vsync_in = vecs[i].vs;
      end
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), uo_out, vecs[i].exp_uo);
    end

    // The output must not change before the next clock edge.
    @(negedge clk) begin color_in = 6'b111010; de_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; end
    @(posedge clk); #1;
    check("pass", uo_out, 8'h9F);
    @(negedge clk) hsync_in = 1'b0;
    #1 check("hs_hold", uo_out, 8'h9F);
    @(posedge clk); #1;
    check("hs_late", uo_out, 8'h1F);
    @(negedge clk) hsync_in = 1'b1;

    // Full swap with one frame per step.
    do_reset();
    request(2'd2);
    #1 check("busy_on", {7'b0, busy}, 8'h01);
    frame_tick(); settle(); check("t1_lvl2", uo_out, 8'hE9);
    frame_tick(); settle(); check("t2_lvl1", uo_out, 8'hF8);
    check("t2_pid", {6'b0, pid}, 8'h00);
    frame_tick(); settle(); check("t3_black", uo_out, 8'h88);
    check("t3_pid", {6'b0, pid}, 8'h02);
    frame_tick(); settle(); check("t4_lvl1", uo_out, 8'hF8);
    frame_tick(); settle(); check("t5_lvl2", uo_out, 8'hE9);
    check("t5_busy", {7'b0, busy}, 8'h01);
    frame_tick(); settle(); check("t6_full", uo_out, 8'h9F);
    check("t6_busy", {7'b0, busy}, 8'h00);
    frame_tick(); settle(); check("idle_full", uo_out, 8'h9F);

    // A second request while busy is ignored and must not extend the fade.
    do_reset();
    request(2'd2);
    frame_tick();
    request(2'd1);
    nt = 1;
    while (busy && nt < 12) begin frame_tick(); nt++; end
    check("busy_ticks", 8'(nt), 8'd6);
    check("busy_pid", {6'b0, pid}, 8'h02);

    // Reset in FADE_IN at lvl 1 discards the request.
    do_reset();
    request(2'd3);
    repeat (4) frame_tick();
    settle(); check("mid_lvl1", uo_out, 8'hF8);
    do_reset();
    settle(); check("mid_full", uo_out, 8'h9F);
    repeat (3) frame_tick();
    settle();
    check("mid_after", uo_out, 8'h9F);
    check("mid_pid", {6'b0, pid}, 8'h00);
    check("mid_busy", {7'b0, busy}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
